// File: rtl/max_pool_2x2_pkg.sv
// Shared VGG package: numeric format and default feature-map geometry used by
// the conv blocks and the pooling block.
//   VGG_DATA_WIDTH  : pixel width (IEEE-754 single precision)
//   FP32_SIGN_BIT   : bit index of the FP32 sign
//   VGG_IMAGE_WIDTH : default input feature-map width/height in pixels
package max_pool_2x2_pkg;

  localparam int VGG_DATA_WIDTH  = 32;
  localparam int FP32_SIGN_BIT   = 31;
  localparam int VGG_IMAGE_WIDTH = 56;

endpackage

// File: rtl/max_pool_2x2_if.sv
// Pixel stream interface for the 2x2 max-pool block.
//   i_valid / i_data : input pixel stream, raster order
//   o_valid / o_data : pooled output stream, raster order of the output map
//   o_done           : pulse with the last pooled pixel of a frame
//
// Handshake: a transfer happens in every cycle where valid is 1; there is no
// ready signal and no backpressure, so the consumer must accept every beat.
// Data is only meaningful while valid is 1.
interface max_pool_2x2_if
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_WIDTH = VGG_DATA_WIDTH
) ();

  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_done;

  // Pooling block side.
  modport slave (
    input  i_valid,
    input  i_data,
    output o_valid,
    output o_data,
    output o_done
  );

  // Producer / consumer side.
  modport master (
    output i_valid,
    output i_data,
    input  o_valid,
    input  o_data,
    input  o_done
  );

endinterface

// File: rtl/max_pool_2x2_fp32_max.sv
// fp32_max: combinational maximum of two FP32 values using a sign-magnitude
// ordering of the raw bits (NaNs are ordered by their bits like any other
// value, nothing is signalled).
//   a, b : operands
//   y    : the larger operand; +0 beats -0, identical bits return that value
module fp32_max
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_WIDTH = VGG_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int S = FP32_SIGN_BIT;

  always_comb begin
    y = a;
    if (a[S] != b[S]) begin
      // Different signs: the non-negative one wins (covers +0 vs -0 too).
      y = a[S] ? b : a;
    end else if (!a[S]) begin
      // Both non-negative: larger magnitude wins.
      y = (a[S-1:0] >= b[S-1:0]) ? a : b;
    end else begin
      // Both negative: smaller magnitude wins.
      y = (a[S-1:0] <= b[S-1:0]) ? a : b;
    end
  end

endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2/stride-2 max pooling of one FP32 channel.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : max_pool_2x2_if.slave (i_valid/i_data in, o_valid/o_data/o_done out)
// Even-column pixels are held in a pair register; the odd-column pixel forms
// the horizontal pair max. Even rows park pair maxima in a half-width line
// buffer; odd rows combine with it and emit one output a cycle later.
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_WIDTH  = VGG_DATA_WIDTH,
  parameter int IMAGE_WIDTH = VGG_IMAGE_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  max_pool_2x2_if.slave  bus
);

  localparam int HALF = IMAGE_WIDTH / 2;
  localparam int CW   = $clog2(IMAGE_WIDTH);
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMAGE_WIDTH - 1);

  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] pair_q;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] line_rd;
  logic [DATA_WIDTH-1:0] vert_max;
  logic [DATA_WIDTH-1:0] line_buf [HALF];
  logic                  col_last;
  logic                  row_last;
  logic                  emit;
  logic                  o_valid_q;
  logic                  o_done_q;
  logic [DATA_WIDTH-1:0] o_data_q;

  assign idx      = IW'(col >> 1);
  assign col_last = (col == LAST);
  assign row_last = (row == LAST);
  assign line_rd  = line_buf[idx];
  // An output is born on the odd-column pixel of an odd row.
  assign emit     = bus.i_valid & col[0] & row[0];

  fp32_max #(.DATA_WIDTH(DATA_WIDTH)) u_pair_max (
    .a (pair_q),
    .b (bus.i_data),
    .y (pair_max)
  );

  fp32_max #(.DATA_WIDTH(DATA_WIDTH)) u_vert_max (
    .a (pair_max),
    .b (line_rd),
    .y (vert_max)
  );

  // Position counters; they only move on accepted pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.i_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_q <= '0;
    end else if (bus.i_valid && !col[0]) begin
      pair_q <= bus.i_data;
    end
  end

  // No reset: every entry is rewritten on an even row before an odd row
  // reads it.
  always_ff @(posedge clk) begin
    if (bus.i_valid && col[0] && !row[0]) begin
      line_buf[idx] <= pair_max;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_done_q  <= 1'b0;
      o_data_q  <= '0;
    end else begin
      o_valid_q <= emit;
      o_done_q  <= emit & col_last & row_last;
      if (emit) begin
        o_data_q <= vert_max;
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_done  = o_done_q;
  assign bus.o_data  = o_data_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Testbench for max_pool_2x2: a 4x4 instance driven from a table of directed
// frames and a 56x56 instance driven with random frames against a model.
module tb_max_pool_2x2;
  import max_pool_2x2_pkg::*;

  typedef struct packed {
    logic [15:0][31:0] px;
    logic [3:0][31:0]  exp;
  } vec_t;

  localparam int W56  = 56;
  localparam int N56  = W56 * W56;
  localparam int O56  = (W56 / 2) * (W56 / 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  max_pool_2x2_if #(.DATA_WIDTH(32)) bus4 ();
  max_pool_2x2_if #(.DATA_WIDTH(32)) bus56 ();

  max_pool_2x2 #(.DATA_WIDTH(32), .IMAGE_WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  max_pool_2x2 #(.DATA_WIDTH(32), .IMAGE_WIDTH(W56)) dut56 (
    .clk (clk),
    .rst (rst),
    .bus (bus56)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- 4x4 monitor ----------------
  int          in_cnt4  = 0;
  bit          last_iv4 = 1'b0;
  logic [31:0] obs_data[$];
  bit          obs_done[$];
  int          obs_idx[$];

  always @(posedge clk) begin
    if (bus4.i_valid) in_cnt4 <= in_cnt4 + 1;
    last_iv4 <= bus4.i_valid;
  end

  always @(negedge clk) begin
    if (bus4.o_valid) begin
      obs_data.push_back(bus4.o_data);
      obs_done.push_back(bus4.o_done);
      obs_idx.push_back(in_cnt4 - 1);
    end
    if (!last_iv4) begin
      checks++;
      if (bus4.o_valid || bus4.o_done) begin
        errors++;
        $display("FAIL quiet_after_gap: o_valid=%0b o_done=%0b, required 0/0 at %0t",
                 bus4.o_valid, bus4.o_done, $time);
      end
    end
  end

  // ---------------- 56x56 scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_e;
  int          out56  = 0;
  int          done56 = 0;

  always @(negedge clk) begin
    if (bus56.o_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL w56_extra: got %h, no output expected", bus56.o_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (bus56.o_data !== exp_e) begin
          errors++;
          $display("FAIL w56_data[%0d]: got %h required %h", out56, bus56.o_data, exp_e);
        end
      end
      checks++;
      if (bus56.o_done !== ((out56 % O56) == O56 - 1)) begin
        errors++;
        $display("FAIL w56_done[%0d]: got %0b required %0b", out56, bus56.o_done,
                 ((out56 % O56) == O56 - 1));
      end
      if (bus56.o_done) done56++;
      out56++;
    end else if (bus56.o_done) begin
      checks++;
      errors++;
      $display("FAIL w56_done_no_valid: o_done=1 with o_valid=0");
    end
  end

  // ---------------- reference model ----------------
  // Monotone key: larger key means larger value under the sign-magnitude order.
  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka;
    logic [31:0] kb;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    return (ka >= kb) ? a : b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive4(input logic [31:0] d);
    @(negedge clk);
    bus4.i_valid = 1'b1;
    bus4.i_data  = d;
  endtask

  task automatic idle4();
    @(negedge clk);
    bus4.i_valid = 1'b0;
    bus4.i_data  = $urandom;
  endtask

  int exp_idx[4] = '{5, 7, 13, 15};

  task automatic run_frame4(input vec_t v, input bit gaps, input string name);
    int base;
    @(negedge clk);
    base = in_cnt4;
    obs_data.delete();
    obs_done.delete();
    obs_idx.delete();
    for (int i = 0; i < 16; i++) begin
      drive4(v.px[i]);
      if (gaps) idle4();
    end
    repeat (4) idle4();
    check({name, "_count"}, 32'(obs_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_data.size()) begin
        check($sformatf("%s_data%0d", name, i), obs_data[i], v.exp[i]);
        check($sformatf("%s_lat%0d", name, i), 32'(obs_idx[i] - base), 32'(exp_idx[i]));
        check($sformatf("%s_done%0d", name, i), 32'(obs_done[i]), 32'(i == 3));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] pos_f[17];
  vec_t        vecs[3];
  logic [31:0] f56[2][N56];
  logic [31:0] m;

  initial begin
    bus4.i_valid  = 1'b0;
    bus4.i_data   = '0;
    bus56.i_valid = 1'b0;
    bus56.i_data  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_o_valid4", 32'(bus4.o_valid), 32'd0);
    check("rst_o_done4", 32'(bus4.o_done), 32'd0);
    check("rst_o_data4", bus4.o_data, 32'h0);
    check("rst_o_valid56", 32'(bus56.o_valid), 32'd0);
    check("rst_o_done56", 32'(bus56.o_done), 32'd0);
    check("rst_o_data56", bus56.o_data, 32'h0);
    rst = 1'b0;

    pos_f = '{32'h0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
              32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
              32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
              32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};

    // 1.0..16.0 -> 6, 8, 14, 16
    for (int i = 0; i < 16; i++) vecs[0].px[i] = pos_f[i+1];
    vecs[0].exp[0] = pos_f[6];
    vecs[0].exp[1] = pos_f[8];
    vecs[0].exp[2] = pos_f[14];
    vecs[0].exp[3] = pos_f[16];
    // -1.0..-16.0 -> -1, -3, -9, -11
    for (int i = 0; i < 16; i++) vecs[1].px[i] = pos_f[i+1] | 32'h8000_0000;
    vecs[1].exp[0] = 32'hBF80_0000;
    vecs[1].exp[1] = 32'hC040_0000;
    vecs[1].exp[2] = 32'hC110_0000;
    vecs[1].exp[3] = 32'hC130_0000;
    // first window {-0, +0, -2, -1} -> +0; rest positive
    vecs[2].px[0]  = 32'h8000_0000;
    vecs[2].px[1]  = 32'h0000_0000;
    vecs[2].px[2]  = pos_f[1];
    vecs[2].px[3]  = pos_f[2];
    vecs[2].px[4]  = 32'hC000_0000;
    vecs[2].px[5]  = 32'hBF80_0000;
    vecs[2].px[6]  = pos_f[3];
    vecs[2].px[7]  = pos_f[4];
    for (int i = 8; i < 16; i++) vecs[2].px[i] = pos_f[i-3];
    vecs[2].exp[0] = 32'h0000_0000;
    vecs[2].exp[1] = pos_f[4];
    vecs[2].exp[2] = pos_f[10];
    vecs[2].exp[3] = pos_f[12];

    for (int i = 0; i < 3; i++) run_frame4(vecs[i], 1'b0, $sformatf("vec%0d", i));
    run_frame4(vecs[0], 1'b1, "gapped");
    run_frame4(vecs[1], 1'b1, "gapped_neg");

    // Abort a frame after 6 pixels (pixel 5 already produced 6.0).
    for (int i = 0; i < 6; i++) drive4(vecs[0].px[i]);
    idle4();
    check("pre_abort_data", bus4.o_data, pos_f[6]);
    rst = 1'b1;
    @(negedge clk);
    check("abort_o_data", bus4.o_data, 32'h0);
    check("abort_o_valid", 32'(bus4.o_valid), 32'd0);
    rst = 1'b0;
    run_frame4(vecs[0], 1'b0, "after_abort");

    // Two back-to-back random 56x56 frames with some special encodings mixed in.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < N56; p++) begin
        case ($urandom_range(0, 15))
          0:       f56[f][p] = 32'h8000_0000;
          1:       f56[f][p] = 32'h0000_0000;
          2:       f56[f][p] = 32'h7FC0_0000;
          3:       f56[f][p] = 32'hFFC0_0000;
          default: f56[f][p] = $urandom;
        endcase
      end
      for (int r = 0; r < W56 / 2; r++) begin
        for (int c = 0; c < W56 / 2; c++) begin
          m = ref_max(f56[f][(2*r)*W56 + 2*c], f56[f][(2*r)*W56 + 2*c + 1]);
          m = ref_max(m, f56[f][(2*r+1)*W56 + 2*c]);
          m = ref_max(m, f56[f][(2*r+1)*W56 + 2*c + 1]);
          exp_q.push_back(m);
        end
      end
    end
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < N56; p++) begin
        @(negedge clk);
        bus56.i_valid = 1'b1;
        bus56.i_data  = f56[f][p];
      end
    end
    @(negedge clk);
    bus56.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("w56_left_in_queue", 32'(exp_q.size()), 32'd0);
    check("w56_out_count", 32'(out56), 32'(2 * O56));
    check("w56_done_count", 32'(done56), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, IEEE-754 single-precision pixel width.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 56, input feature-map width and height in pixels; even, at least 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port i_valid, input, 1 bit, qualifies i_data for one cycle; there is no backpressure.
REQ-006 SHALL have port i_data, input, DATA_WIDTH bits, one input pixel of one channel, raster order (row-major).
REQ-007 SHALL have port o_valid, output, 1 bit, qualifies o_data for one cycle.
REQ-008 SHALL have port o_data, output, DATA_WIDTH bits, max of one 2x2 window, raster order of the output map.
REQ-009 SHALL have port o_done, output, 1 bit, one-cycle pulse coincident with the last output pixel of a frame.

Function
REQ-010 SHALL count input column col (0..IMAGE_WIDTH-1) and row row (0..IMAGE_WIDTH-1), advancing only on i_valid.
REQ-011 SHALL wrap col to 0 and increment row when col = IMAGE_WIDTH-1; on that pixel at row = IMAGE_WIDTH-1, both SHALL wrap to 0 and the next i_valid starts a new frame with no idle cycle required.
REQ-012 SHALL hold the even-column pixel in a pair register, and on the odd-column pixel form pair_max = max(pair register, i_data).
REQ-013 On even rows, SHALL write pair_max into a line buffer of IMAGE_WIDTH/2 entries at index col/2.
REQ-014 On odd rows, SHALL compute max(pair_max, line buffer[col/2]) and register it to o_data with o_valid = 1 on the next cycle (latency 1 cycle after the odd-row, odd-column input).
REQ-015 SHALL produce exactly (IMAGE_WIDTH/2)^2 outputs per frame.
REQ-016 SHALL assert o_done with the output generated from row = col = IMAGE_WIDTH-1.
REQ-017 Max compare SHALL be a sign-magnitude ordering of raw bits: a positive operand beats a negative one; two positives compare larger magnitude wins; two negatives compare smaller magnitude wins.
REQ-018 SHALL treat +0 vs -0 as +0 winning, and the equal-bits case as returning that value.
REQ-019 NaN inputs SHALL be ordered by raw bits per REQ-017 (deterministic, no exception signalling).
REQ-020 Gaps in i_valid at any position SHALL NOT change results; counters and buffers SHALL hold.
REQ-021 o_valid and o_done SHALL be 0 in every cycle not producing an output; o_data SHALL hold its last value when o_valid = 0.

Reset
REQ-022 rst SHALL asynchronously clear col, row, o_valid and o_done to 0, and o_data and the pair register to 0.
REQ-023 Line buffer contents SHALL need no reset; even rows always overwrite them before use.
REQ-024 rst asserted mid-frame SHALL discard the partial frame; the first i_valid after deassertion is pixel (0,0).

Structure
REQ-025 DATA_WIDTH default, the FP32 sign-bit index and the default IMAGE_WIDTH SHALL live in the shared VGG package used by the conv blocks.
REQ-026 The compare SHALL be one combinational sub-module, fp32_max, instantiated twice (pair max and vertical max).
REQ-027 The line buffer SHALL be an inferred register array of depth IMAGE_WIDTH/2, written and read at the same index in different row parities.

Verification
REQ-028 Scenario 1: IMAGE_WIDTH=4, inputs 1.0..16.0 raster, continuous i_valid -> outputs 6.0, 8.0, 14.0, 16.0; o_done with 16.0; each output 1 cycle after pixels 5, 7, 13, 15 (0-based).
REQ-029 Scenario 2: IMAGE_WIDTH=4, all negatives -1.0..-16.0 -> outputs -1.0, -3.0, -9.0, -11.0.
REQ-030 Scenario 3: window {-0.0, +0.0, -2.0, -1.0} -> o_data = 32'h00000000.
REQ-031 Scenario 4: Scenario 1 with i_valid deasserted every other cycle -> same values; o_valid never asserted during gaps.
REQ-032 Scenario 5: rst pulsed after 6 pixels, then a full frame of Scenario 1 -> exactly 4 outputs matching Scenario 1, none from the aborted frame.
REQ-033 Scenario 6: two back-to-back frames at IMAGE_WIDTH=56 with random FP32 data, compared against a reference model -> 784 outputs each, and o_done twice.
